// File: rtl/hnf_sn_req_issue_pkg.sv
// CHI request-flit types and link constants shared by the HN-F to SN-F issue path.
package hnf_sn_req_issue_pkg;

   localparam int CHI_TXNID_RANGE = 8;
   localparam int CHI_NODEID_W    = 7;
   localparam int CHI_ADDR_W      = 44;

   typedef logic [CHI_TXNID_RANGE-1:0] chi_txnid_t;
   typedef logic [CHI_NODEID_W-1:0]    chi_nodeid_t;
   typedef logic [5:0]                 chi_opcode_t;

   localparam chi_opcode_t OP_ReadNoSnp = 6'h04;

   // CHI caps the link credits a transmitter may hold at 15.
   localparam int numCreditsForHNReq = 15;
   localparam int MAX_LCRD           = numCreditsForHNReq;

   typedef struct packed {
      chi_nodeid_t           tgt_id;
      chi_nodeid_t           src_id;
      chi_txnid_t            txn_id;
      chi_nodeid_t           return_nid;
      chi_txnid_t            return_txn_id;
      chi_opcode_t           opcode;
      logic [2:0]            size;
      logic [CHI_ADDR_W-1:0] addr;
   } reqflit_t;

endpackage

// File: rtl/hnf_sn_req_issue_if.sv
// Lookup-side and SN-F-side signals of the ReadNoSnp issue stage; slave is the issue stage itself.
interface hnf_sn_req_issue_if #(
   parameter int TRK_DEPTH = 8
);
   import hnf_sn_req_issue_pkg::*;

   reqflit_t                             read_no_snp;
   logic                                 read_no_snp_v;
   logic                                 txreqflitpend;
   logic                                 txreqflitv;
   reqflit_t                             txreqflit;
   logic                                 txreqlcrdv;
   logic                                 sn_done_v;
   chi_txnid_t                           sn_done_txnid;
   logic                                 fifo_full;
   logic [$clog2(TRK_DEPTH + 1)-1:0]     trk_cnt;
   logic                                 overflow_err;
   logic                                 proto_err;

   modport slave (
      input  read_no_snp, read_no_snp_v, txreqlcrdv, sn_done_v, sn_done_txnid,
      output txreqflitpend, txreqflitv, txreqflit, fifo_full, trk_cnt, overflow_err, proto_err
   );

   modport master (
      output read_no_snp, read_no_snp_v, txreqlcrdv, sn_done_v, sn_done_txnid,
      input  txreqflitpend, txreqflitv, txreqflit, fifo_full, trk_cnt, overflow_err, proto_err
   );

endinterface

// File: rtl/hnf_req_fifo.sv
// Generic reqflit_t FIFO, head visible combinationally; push and pop both take effect at the edge.
// No internal backpressure: a push while full is only legal together with a pop.
module hnf_req_fifo
   import hnf_sn_req_issue_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  reqflit_t         push_dat_i,
   input  logic             pop_i,
   output reqflit_t         head_dat_o,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] count_o
);

   reqflit_t         mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (push_i && !pop_i) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (!push_i && pop_i) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   // DEPTH is a power of two, so the pointers wrap naturally.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         cnt_q <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
   end

   assign head_dat_o = mem_q[rd_ptr_q];
   assign full_o     = (cnt_q == CNT_W'(DEPTH));
   assign empty_o    = (cnt_q == '0);
   assign count_o    = cnt_q;

endmodule

// File: rtl/hnf_sn_req_issue.sv
// HN-F ReadNoSnp issue stage: buffers lookup flits, drives TXREQ under link credits, tracks TxnIDs.
// Define HNF_SN_REQ_BYPASS_EN to let a flit skip an idle FIFO (1-cycle instead of 2-cycle latency).
module hnf_sn_req_issue #(
   parameter int FIFO_DEPTH = 4,
   parameter int TRK_DEPTH  = 8,
   parameter int MAX_LCRD   = hnf_sn_req_issue_pkg::numCreditsForHNReq
) (
   input logic               clock_i,
   input logic               reset_ni,
   hnf_sn_req_issue_if.slave sn_if
);
   import hnf_sn_req_issue_pkg::*;

   localparam int LCRD_W    = $clog2(MAX_LCRD + 1);
   localparam int TRK_CNT_W = $clog2(TRK_DEPTH + 1);
   localparam int FCNT_W    = $clog2(FIFO_DEPTH + 1);

   reqflit_t            fifo_head, issue_flit, txreqflit_q;
   logic                fifo_empty, fifo_full, fifo_push, fifo_pop;
   logic [FCNT_W-1:0]   fifo_count;
   logic                lcrd_avail, trk_free, issue, byp, drop;
   logic                txreqflitv_q, overflow_err_q, proto_err_q;
   logic                trk_proto, lcrd_proto, retire_hit, alloc_done;
   logic [LCRD_W-1:0]   lcrd_cnt_q, lcrd_cnt_d;
   logic [TRK_DEPTH-1:0] trk_vld_q, trk_vld_d;
   chi_txnid_t          trk_id_q [TRK_DEPTH];
   chi_txnid_t          trk_id_d [TRK_DEPTH];
   logic [TRK_CNT_W-1:0] trk_cnt_q, trk_cnt_d;

   hnf_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i      (clock_i),
      .rst_ni     (reset_ni),
      .push_i     (fifo_push),
      .push_dat_i (sn_if.read_no_snp),
      .pop_i      (fifo_pop),
      .head_dat_o (fifo_head),
      .full_o     (fifo_full),
      .empty_o    (fifo_empty),
      .count_o    (fifo_count)
   );

   // Free-entry check uses registered state, so a same-cycle retire cannot be reused until next cycle.
   assign lcrd_avail = (lcrd_cnt_q != '0);
   assign trk_free   = ~&trk_vld_q;

`ifdef HNF_SN_REQ_BYPASS_EN
   assign byp = sn_if.read_no_snp_v & fifo_empty & ~txreqflitv_q & lcrd_avail & trk_free;
`else
   assign byp = 1'b0;
`endif

   // byp requires an empty FIFO, so it never coincides with a pop and ordering is kept.
   assign fifo_pop   = ~fifo_empty & lcrd_avail & trk_free;
   assign issue      = fifo_pop | byp;
   assign issue_flit = byp ? sn_if.read_no_snp : fifo_head;
   assign fifo_push  = sn_if.read_no_snp_v & ~byp & (~fifo_full | fifo_pop);
   assign drop       = sn_if.read_no_snp_v & ~byp & fifo_full & ~fifo_pop;

   always_comb begin
      lcrd_cnt_d = lcrd_cnt_q;
      lcrd_proto = 1'b0;
      if (sn_if.txreqlcrdv && !issue) begin
         if (lcrd_cnt_q == LCRD_W'(MAX_LCRD)) begin
            lcrd_proto = 1'b1;
         end else begin
            lcrd_cnt_d = lcrd_cnt_q + LCRD_W'(1);
         end
      end else if (!sn_if.txreqlcrdv && issue) begin
         lcrd_cnt_d = lcrd_cnt_q - LCRD_W'(1);
      end
   end

   always_comb begin
      trk_vld_d  = trk_vld_q;
      trk_id_d   = trk_id_q;
      trk_proto  = 1'b0;
      retire_hit = 1'b0;
      alloc_done = 1'b0;
      if (sn_if.sn_done_v) begin
         for (int i = 0; i < TRK_DEPTH; i++) begin
            if (!retire_hit && trk_vld_q[i] && (trk_id_q[i] == sn_if.sn_done_txnid)) begin
               trk_vld_d[i] = 1'b0;
               retire_hit   = 1'b1;
            end
         end
         if (!retire_hit) trk_proto = 1'b1;
      end
      if (issue) begin
         // Duplicate check runs after retire so a TxnID completing this cycle may be reused.
         for (int i = 0; i < TRK_DEPTH; i++) begin
            if (trk_vld_d[i] && (trk_id_d[i] == issue_flit.txn_id)) trk_proto = 1'b1;
         end
         for (int i = 0; i < TRK_DEPTH; i++) begin
            if (!alloc_done && !trk_vld_q[i]) begin
               trk_vld_d[i] = 1'b1;
               trk_id_d[i]  = issue_flit.txn_id;
               alloc_done   = 1'b1;
            end
         end
      end
   end

   always_comb begin
      trk_cnt_d = '0;
      for (int i = 0; i < TRK_DEPTH; i++) begin
         trk_cnt_d = trk_cnt_d + TRK_CNT_W'(trk_vld_d[i]);
      end
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         lcrd_cnt_q     <= '0;
         trk_vld_q      <= '0;
         trk_cnt_q      <= '0;
         txreqflitv_q   <= 1'b0;
         txreqflit_q    <= '0;
         overflow_err_q <= 1'b0;
         proto_err_q    <= 1'b0;
         for (int i = 0; i < TRK_DEPTH; i++) trk_id_q[i] <= '0;
      end else begin
         lcrd_cnt_q     <= lcrd_cnt_d;
         trk_vld_q      <= trk_vld_d;
         trk_id_q       <= trk_id_d;
         trk_cnt_q      <= trk_cnt_d;
         txreqflitv_q   <= issue;
         if (issue) txreqflit_q <= issue_flit;
         overflow_err_q <= overflow_err_q | drop;
         proto_err_q    <= proto_err_q | trk_proto | lcrd_proto;
      end
   end

   assign sn_if.txreqflitv    = txreqflitv_q;
   assign sn_if.txreqflit     = txreqflit_q;
   assign sn_if.txreqflitpend = (fifo_count != '0) | txreqflitv_q;
   assign sn_if.fifo_full     = fifo_full;
   assign sn_if.trk_cnt       = trk_cnt_q;
   assign sn_if.overflow_err  = overflow_err_q;
   assign sn_if.proto_err     = proto_err_q;

endmodule

// File: tb/tb_hnf_sn_req_issue.sv
// Directed bench for hnf_sn_req_issue: reset, issue latency/order, FIFO overflow, tracker limits, credit and protocol errors.
module tb_hnf_sn_req_issue;
   import hnf_sn_req_issue_pkg::*;

`ifdef HNF_SN_REQ_BYPASS_EN
   localparam logic BYP = 1'b1;
`else
   localparam logic BYP = 1'b0;
`endif

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   vectors     = 0;
   int   miscompares = 0;

   hnf_sn_req_issue_if #(.TRK_DEPTH(8)) bif ();

   hnf_sn_req_issue #(.FIFO_DEPTH(4), .TRK_DEPTH(8), .MAX_LCRD(15)) dut (
      .clock_i  (clk),
      .reset_ni (rst_n),
      .sn_if    (bif)
   );

   always #5 clk = ~clk;

   function automatic reqflit_t mk(input logic [7:0] id, input logic [43:0] addr);
      reqflit_t f;
      f.tgt_id        = 7'h20;
      f.src_id        = 7'h05;
      f.txn_id        = id;
      f.return_nid    = 7'h11;
      f.return_txn_id = id ^ 8'h80;
      f.opcode        = OP_ReadNoSnp;
      f.size          = 3'd6;
      f.addr          = addr;
      return f;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chkb(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
      end
   endtask

   task automatic chkn(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chkf(input string tag, input reqflit_t obs, input reqflit_t exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic push(input reqflit_t f);
      bif.read_no_snp   = f;
      bif.read_no_snp_v = 1'b1;
      tick();
      bif.read_no_snp_v = 1'b0;
   endtask

   task automatic retire(input logic [7:0] id);
      bif.sn_done_v     = 1'b1;
      bif.sn_done_txnid = id;
      tick();
      bif.sn_done_v     = 1'b0;
   endtask

   task automatic credits(input int n);
      bif.txreqlcrdv = 1'b1;
      repeat (n) tick();
      bif.txreqlcrdv = 1'b0;
   endtask

   task automatic pulse_reset();
      #2 rst_n = 1'b0;
      #4 rst_n = 1'b1;
      tick();
   endtask

   initial begin
      bif.read_no_snp   = '0;
      bif.read_no_snp_v = 1'b0;
      bif.txreqlcrdv    = 1'b0;
      bif.sn_done_v     = 1'b0;
      bif.sn_done_txnid = '0;

      // Reset state
      #3;
      chkb("rst_flitv", bif.txreqflitv, 1'b0);
      chkb("rst_pend", bif.txreqflitpend, 1'b0);
      chkb("rst_full", bif.fifo_full, 1'b0);
      chkb("rst_ovf", bif.overflow_err, 1'b0);
      chkb("rst_proto", bif.proto_err, 1'b0);
      chkn("rst_trk", 8'(bif.trk_cnt), 8'd0);
      #9 rst_n = 1'b1;
      tick();

      // Single flit, then one credit
      push(mk(8'h12, 44'h1000));
      chkb("s1_noissue", bif.txreqflitv, 1'b0);
      chkb("s1_pend", bif.txreqflitpend, 1'b1);
      credits(1);
      chkb("s1_wait", bif.txreqflitv, 1'b0);
      tick();
      chkb("s1_v", bif.txreqflitv, 1'b1);
      chkf("s1_flit", bif.txreqflit, mk(8'h12, 44'h1000));
      chkn("s1_trk", 8'(bif.trk_cnt), 8'd1);
      chkn("s1_lcrd", 8'(dut.lcrd_cnt_q), 8'd0);
      tick();
      chkb("s1_pulse", bif.txreqflitv, 1'b0);
      chkb("s1_pend_idle", bif.txreqflitpend, 1'b0);

      // Latency with credit already held
      credits(1);
      push(mk(8'h13, 44'h1100));
      chkb("lat_edgeN", bif.txreqflitv, BYP);
      tick();
      chkb("lat_edgeN1", bif.txreqflitv, ~BYP);
      chkf("lat_flit", bif.txreqflit, mk(8'h13, 44'h1100));
      tick();
      chkb("lat_done", bif.txreqflitv, 1'b0);
      chkn("lat_trk", 8'(bif.trk_cnt), 8'd2);
      retire(8'h12);
      retire(8'h13);
      chkn("ret_trk", 8'(bif.trk_cnt), 8'd0);
      chkb("ret_proto", bif.proto_err, 1'b0);

      // Zero credits, three flits, then three consecutive credits
      for (int i = 0; i < 3; i++) push(mk(8'(32'h20 + i), 44'(32'h2000 + 64 * i)));
      chkb("s2_hold", bif.txreqflitv, 1'b0);
      chkb("s2_pend", bif.txreqflitpend, 1'b1);
      bif.txreqlcrdv = 1'b1;
      tick();
      chkb("s2_c1", bif.txreqflitv, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         if (i == 1) bif.txreqlcrdv = 1'b0;
         chkb("s2_v", bif.txreqflitv, 1'b1);
         chkf("s2_order", bif.txreqflit, mk(8'(32'h20 + i), 44'(32'h2000 + 64 * i)));
      end
      tick();
      chkb("s2_end_v", bif.txreqflitv, 1'b0);
      chkb("s2_end_pend", bif.txreqflitpend, 1'b0);
      chkn("s2_lcrd", 8'(dut.lcrd_cnt_q), 8'd0);
      chkn("s2_trk", 8'(bif.trk_cnt), 8'd3);
      for (int i = 0; i < 3; i++) retire(8'(32'h20 + i));

      // FIFO overflow: fifth push dropped
      for (int i = 0; i < 5; i++) begin
         push(mk(8'(32'h30 + i), 44'(32'h3000 + 64 * i)));
         if (i == 3) begin
            chkb("s3_full4", bif.fifo_full, 1'b1);
            chkb("s3_noovf", bif.overflow_err, 1'b0);
         end
      end
      chkb("s3_ovf", bif.overflow_err, 1'b1);
      chkb("s3_full5", bif.fifo_full, 1'b1);
      bif.txreqlcrdv = 1'b1;
      tick();
      chkb("s3_c1", bif.txreqflitv, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         if (i == 2) bif.txreqlcrdv = 1'b0;
         chkb("s3_v", bif.txreqflitv, 1'b1);
         chkf("s3_order", bif.txreqflit, mk(8'(32'h30 + i), 44'(32'h3000 + 64 * i)));
      end
      tick();
      chkb("s3_drop_pend", bif.txreqflitpend, 1'b0);
      chkb("s3_not_full", bif.fifo_full, 1'b0);
      for (int i = 0; i < 4; i++) retire(8'(32'h30 + i));
      chkn("s3_trk", 8'(bif.trk_cnt), 8'd0);

      // Tracker full: ninth flit waits for a retire
      credits(9);
      chkn("s4_lcrd9", 8'(dut.lcrd_cnt_q), 8'd9);
      for (int i = 0; i < 9; i++) push(mk(8'(32'h40 + i), 44'(32'h4000 + 64 * i)));
      tick();
      chkb("s4_held", bif.txreqflitv, 1'b0);
      chkn("s4_trk8", 8'(bif.trk_cnt), 8'd8);
      chkb("s4_pend", bif.txreqflitpend, 1'b1);
      chkn("s4_lcrd1", 8'(dut.lcrd_cnt_q), 8'd1);
      retire(8'h42);
      chkb("s4_ret_cycle", bif.txreqflitv, 1'b0);
      chkn("s4_trk7", 8'(bif.trk_cnt), 8'd7);
      tick();
      chkb("s4_v9", bif.txreqflitv, 1'b1);
      chkf("s4_flit9", bif.txreqflit, mk(8'h48, 44'h4200));
      chkn("s4_trk_again8", 8'(bif.trk_cnt), 8'd8);
      tick();
      for (int i = 0; i < 9; i++) if (i != 2) retire(8'(32'h40 + i));
      chkn("s4_trk0", 8'(bif.trk_cnt), 8'd0);
      chkb("s4_proto", bif.proto_err, 1'b0);

      // Async reset mid-burst: two queued, one outstanding
      credits(1);
      push(mk(8'h60, 44'h6000));
      push(mk(8'h61, 44'h6040));
      push(mk(8'h62, 44'h6080));
      tick();
      chkn("s6_pre_trk", 8'(bif.trk_cnt), 8'd1);
      chkb("s6_pre_pend", bif.txreqflitpend, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chkb("s6_flitv", bif.txreqflitv, 1'b0);
      chkb("s6_pend", bif.txreqflitpend, 1'b0);
      chkn("s6_trk", 8'(bif.trk_cnt), 8'd0);
      chkb("s6_ovf", bif.overflow_err, 1'b0);
      chkb("s6_full", bif.fifo_full, 1'b0);
      chkn("s6_lcrd", 8'(dut.lcrd_cnt_q), 8'd0);
      #4 rst_n = 1'b1;
      tick();

      // Credit saturation; queued flits must not reappear
      bif.txreqlcrdv = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         tick();
         if (i == 15) begin
            chkn("s5_lcrd15", 8'(dut.lcrd_cnt_q), 8'd15);
            chkb("s5_proto_ok", bif.proto_err, 1'b0);
            chkb("s5_lost_pend", bif.txreqflitpend, 1'b0);
         end
      end
      bif.txreqlcrdv = 1'b0;
      chkn("s5_lcrd_sat", 8'(dut.lcrd_cnt_q), 8'd15);
      chkb("s5_proto_lcrd", bif.proto_err, 1'b1);

      // Duplicate TxnID: flagged but still allocated
      pulse_reset();
      credits(2);
      push(mk(8'h70, 44'h7000));
      push(mk(8'h70, 44'h7040));
      chkb("dup_first", bif.proto_err, 1'b0);
      tick();
      chkb("dup_proto", bif.proto_err, 1'b1);
      chkn("dup_trk", 8'(bif.trk_cnt), 8'd2);

      // Completion for a TxnID never issued
      pulse_reset();
      chkb("unk_pre", bif.proto_err, 1'b0);
      retire(8'h7F);
      chkb("unk_proto", bif.proto_err, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
